// File: rtl/syncgen.sv
// syncgen: VGA-style raster timing generator.
//
// Produces horizontal/vertical position counters and registered sync,
// display-enable and frame-start strobes for a raster defined by the
// porch/pulse parameters. Counting is gated by the clock generator's lock
// status, which is brought into the pixel clock domain by a two-flop
// synchroniser. Losing lock parks the raster at (0,0) with idle outputs, and
// regaining lock restarts it from (0,0).
//
// Ports
//   pck      in   pixel clock (only clock)
//   rst_n    in   asynchronous active-low reset
//   locked   in   clock-generator lock, asynchronous to pck
//   hcnt     out  [9:0] horizontal position within the line
//   vcnt     out  [9:0] vertical line within the frame
//   hsync    out  horizontal sync, active low
//   vsync    out  vertical sync, active low
//   disp_en  out  high while (hcnt, vcnt) lies in the visible area
//   frame    out  one-cycle pulse as the raster steps into (0,0)
module syncgen #(
  parameter int unsigned HVISIBLE = 640,
  parameter int unsigned HFRONT   = 16,
  parameter int unsigned HWIDTH   = 96,
  parameter int unsigned HBACK    = 48,
  parameter int unsigned VVISIBLE = 480,
  parameter int unsigned VFRONT   = 10,
  parameter int unsigned VWIDTH   = 2,
  parameter int unsigned VBACK    = 33
) (
  input  logic       pck,
  input  logic       rst_n,
  input  logic       locked,
  output logic [9:0] hcnt,
  output logic [9:0] vcnt,
  output logic       hsync,
  output logic       vsync,
  output logic       disp_en,
  output logic       frame
);

  localparam int unsigned HPERIOD = HVISIBLE + HFRONT + HWIDTH + HBACK;
  localparam int unsigned VPERIOD = VVISIBLE + VFRONT + VWIDTH + VBACK;

  localparam logic [9:0] HLast    = 10'(HPERIOD - 1);
  localparam logic [9:0] VLast    = 10'(VPERIOD - 1);
  localparam logic [9:0] HVis     = 10'(HVISIBLE);
  localparam logic [9:0] VVis     = 10'(VVISIBLE);
  localparam logic [9:0] HSyncBeg = 10'(HVISIBLE + HFRONT);
  localparam logic [9:0] HSyncEnd = 10'(HVISIBLE + HFRONT + HWIDTH - 1);
  localparam logic [9:0] VSyncBeg = 10'(VVISIBLE + VFRONT);
  localparam logic [9:0] VSyncEnd = 10'(VVISIBLE + VFRONT + VWIDTH - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic       sync1_q, sync2_q;
  logic       run;
  state_e     state_q, state_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_en_q, disp_en_d;
  logic       frame_q, frame_d;
  logic       hwrap, vwrap;

  // Two-flop synchroniser for the asynchronous lock status.
  always_ff @(posedge pck or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
    end
  end

  assign run   = sync2_q;
  assign hwrap = (hcnt_q == HLast);
  assign vwrap = (vcnt_q == VLast);

  // Outputs are decoded from the next counter values and registered together
  // with the counters, so every strobe lines up with the position it
  // describes and none of them is a combinational decode.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = '0;
    vcnt_d    = '0;
    hsync_d   = 1'b1;
    vsync_d   = 1'b1;
    disp_en_d = 1'b0;
    frame_d   = 1'b0;

    unique case (state_q)
      // The first run cycle presents (0,0) rather than incrementing, so the
      // raster always starts from the origin after reset or re-lock.
      StIdle: begin
        if (run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!run) begin
          state_d = StIdle;
        end else begin
          if (hwrap) begin
            hcnt_d = '0;
            vcnt_d = vwrap ? 10'd0 : vcnt_q + 10'd1;
          end else begin
            hcnt_d = hcnt_q + 10'd1;
            vcnt_d = vcnt_q;
          end
          frame_d = hwrap && vwrap;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StRun) begin
      hsync_d   = !((hcnt_d >= HSyncBeg) && (hcnt_d <= HSyncEnd));
      vsync_d   = !((vcnt_d >= VSyncBeg) && (vcnt_d <= VSyncEnd));
      disp_en_d = (hcnt_d < HVis) && (vcnt_d < VVis);
    end
  end

  always_ff @(posedge pck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      disp_en_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      disp_en_q <= disp_en_d;
      frame_q   <= frame_d;
    end
  end

  assign hcnt    = hcnt_q;
  assign vcnt    = vcnt_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign disp_en = disp_en_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_syncgen.sv
// Bench for syncgen. Uses a shrunken raster (32 x 19) so whole frames fit in
// a short run; all expectations are derived from the same parameters.
module tb_syncgen;

  localparam int HV = 16, HF = 4, HW = 6, HB = 6;
  localparam int VV = 12, VF = 2, VW = 2, VB = 3;
  localparam int HP = HV + HF + HW + HB;
  localparam int VP = VV + VF + VW + VB;
  localparam int FL = HP * VP;
  localparam int HS0 = HV + HF;
  localparam int HS1 = HV + HF + HW - 1;
  localparam int VS0 = VV + VF;
  localparam int VS1 = VV + VF + VW - 1;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fr;
  } obs_t;

  logic       pck = 1'b0;
  logic       rst_n;
  logic       locked;
  logic [9:0] hcnt, vcnt;
  logic       hsync, vsync, disp_en, frame;

  int total = 0;
  int bad   = 0;

  obs_t sbq[$];
  logic m_active;
  int   m_h, m_v;

  syncgen #(
    .HVISIBLE(HV), .HFRONT(HF), .HWIDTH(HW), .HBACK(HB),
    .VVISIBLE(VV), .VFRONT(VF), .VWIDTH(VW), .VBACK(VB)
  ) dut (
    .pck    (pck),
    .rst_n  (rst_n),
    .locked (locked),
    .hcnt   (hcnt),
    .vcnt   (vcnt),
    .hsync  (hsync),
    .vsync  (vsync),
    .disp_en(disp_en),
    .frame  (frame)
  );

  always #5 pck = ~pck;

  function automatic obs_t idle_obs();
    obs_t o;
    o.h = '0; o.v = '0; o.hs = 1'b1; o.vs = 1'b1; o.de = 1'b0; o.fr = 1'b0;
    return o;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Lock driven now takes effect on the outputs two edges later; push the
  // expected raster state for that future edge.
  task automatic push_expect(input logic lk);
    obs_t e;
    e = idle_obs();
    if (!lk) begin
      m_active = 1'b0; m_h = 0; m_v = 0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1; m_h = 0; m_v = 0;
      end else begin
        e.fr = (m_h == HP - 1) && (m_v == VP - 1);
        m_h++;
        if (m_h == HP) begin
          m_h = 0;
          m_v++;
          if (m_v == VP) m_v = 0;
        end
      end
      e.h  = 10'(m_h);
      e.v  = 10'(m_v);
      e.hs = !(m_h >= HS0 && m_h <= HS1);
      e.vs = !(m_v >= VS0 && m_v <= VS1);
      e.de = (m_h < HV) && (m_v < VV);
    end
    sbq.push_back(e);
  endtask

  task automatic reset_model();
    sbq.delete();
    sbq.push_back(idle_obs());
    sbq.push_back(idle_obs());
    m_active = 1'b0; m_h = 0; m_v = 0;
  endtask

  task automatic tick(input logic lk);
    obs_t got, exp;
    locked = lk;
    push_expect(lk);
    @(posedge pck);
    #1;
    got = {hcnt, vcnt, hsync, vsync, disp_en, frame};
    exp = sbq.pop_front();
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL sb got h=%0d v=%0d hs=%b vs=%b de=%b fr=%b expected h=%0d v=%0d hs=%b vs=%b de=%b fr=%b",
             got.h, got.v, got.hs, got.vs, got.de, got.fr,
             exp.h, exp.v, exp.hs, exp.vs, exp.de, exp.fr);
    end
  endtask

  initial begin
    int n, viol, hs_cnt, vs_cnt, de_cnt, fr_cnt, lines, hrun, bad_runs;
    int hs_first, vs_first_v, vs_first_h;
    logic found;

    rst_n  = 1'b0;
    locked = 1'b0;
    #23;
    check("rst_hcnt", int'(hcnt), 0);
    check("rst_vcnt", int'(vcnt), 0);
    check("rst_hsync", int'(hsync), 1);
    check("rst_vsync", int'(vsync), 1);
    check("rst_de", int'(disp_en), 0);
    check("rst_frame", int'(frame), 0);

    // Unlocked for 1000 cycles: raster parked.
    @(posedge pck);
    #1;
    rst_n = 1'b1;
    reset_model();
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0);
      if (hcnt != 0 || vcnt != 0 || hsync !== 1'b1 || vsync !== 1'b1 || disp_en !== 1'b0 ||
          frame !== 1'b0) viol++;
    end
    check("unlocked_idle", viol, 0);

    // Lock gain: first active cycle within 3 edges at the origin.
    n = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b1); n++;
      if (disp_en === 1'b1) found = 1'b1;
    end
    check("lock_found", int'(found), 1);
    check("lock_within3", int'(n <= 3), 1);
    check("lock_h0", int'(hcnt), 0);
    check("lock_v0", int'(vcnt), 0);

    // First frame: no pulse until exactly one frame length later.
    n = 0; found = 1'b0;
    for (int i = 0; i < 2 * FL && !found; i++) begin
      tick(1'b1); n++;
      if (frame === 1'b1) found = 1'b1;
    end
    check("first_pulse_found", int'(found), 1);
    check("first_frame_len", n, FL);
    check("pulse_at_origin", int'(hcnt == 0 && vcnt == 0), 1);

    // One full frame window starting at the pulse cycle.
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; fr_cnt = 0; lines = 0; hrun = 0; bad_runs = 0;
    hs_first = -1; vs_first_v = -1; vs_first_h = -1;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick(1'b1);
      if (!hsync) begin
        hs_cnt++; hrun++;
        if (hs_first < 0) hs_first = int'(hcnt);
      end else if (hrun != 0) begin
        if (hrun != HW) bad_runs++;
        hrun = 0;
      end
      if (!vsync) begin
        vs_cnt++;
        if (vs_first_v < 0) begin
          vs_first_v = int'(vcnt);
          vs_first_h = int'(hcnt);
        end
      end
      if (disp_en) de_cnt++;
      if (frame) fr_cnt++;
      if (hcnt == 0) lines++;
    end
    check("hsync_low_total", hs_cnt, HW * VP);
    check("hsync_run_len", bad_runs, 0);
    check("hsync_start", hs_first, HS0);
    check("vsync_low_total", vs_cnt, VW * HP);
    check("vsync_start_line", vs_first_v, VS0);
    check("vsync_start_h", vs_first_h, 0);
    check("de_total", de_cnt, HV * VV);
    check("pulses_per_frame", fr_cnt, 1);
    check("lines_per_frame", lines, VP);
    tick(1'b1);
    check("next_pulse", int'(frame), 1);
    check("next_origin", int'(hcnt == 0 && vcnt == 0), 1);
    tick(1'b1);
    check("pulse_single", int'(frame), 0);

    // Lock loss mid-frame.
    found = 1'b0;
    for (int i = 0; i < 2 * FL && !found; i++) begin
      tick(1'b1);
      if (vcnt == 7 && hcnt == 10) found = 1'b1;
    end
    check("drop_point_found", int'(found), 1);
    tick(1'b0);
    tick(1'b0);
    check("drop_still_running", int'(hcnt), 12);
    tick(1'b0);
    check("drop_idle", int'(hcnt == 0 && vcnt == 0 && hsync && vsync && !disp_en && !frame), 1);
    for (int i = 0; i < 20; i++) tick(1'b0);
    n = 0; found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b1); n++;
      if (disp_en === 1'b1) found = 1'b1;
    end
    check("relock_within3", int'(found && n <= 3), 1);
    check("relock_origin", int'(hcnt == 0 && vcnt == 0 && hsync && vsync && !frame), 1);

    // Asynchronous reset in the middle of HSYNC.
    found = 1'b0;
    for (int i = 0; i < 2 * HP && !found; i++) begin
      tick(1'b1);
      if (hcnt == 10'(HS0 + 2)) found = 1'b1;
    end
    check("pre_rst_hsync", int'(found && !hsync), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_hsync", int'(hsync), 1);
    check("async_hcnt", int'(hcnt), 0);
    check("async_vcnt", int'(vcnt), 0);
    check("async_de", int'(disp_en), 0);
    repeat (3) @(posedge pck);
    #1;
    rst_n = 1'b1;
    reset_model();
    tick(1'b1);
    tick(1'b1);
    check("rst_exit_e2_idle", int'(disp_en), 0);
    tick(1'b1);
    check("rst_exit_e3_origin", int'(hcnt == 0 && disp_en), 1);
    tick(1'b1);
    check("rst_exit_e4_inc", int'(hcnt), 1);
    for (int i = 0; i < 3 * HP; i++) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syncgen.md
SYNCGEN -- requirements
Module: syncgen

Interface
REQ-001 SHALL have parameter HVISIBLE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter HFRONT, default 16, meaning horizontal front porch in PCK cycles.
REQ-003 SHALL have parameter HWIDTH, default 96, meaning HSYNC pulse width in PCK cycles.
REQ-004 SHALL have parameter HBACK, default 48, meaning horizontal back porch in PCK cycles.
REQ-005 SHALL have parameter VVISIBLE, default 480, meaning active lines per frame.
REQ-006 SHALL have parameter VFRONT, default 10, meaning vertical front porch in lines.
REQ-007 SHALL have parameter VWIDTH, default 2, meaning VSYNC pulse width in lines.
REQ-008 SHALL have parameter VBACK, default 33, meaning vertical back porch in lines.
REQ-009 SHALL have port PCK, input, 1, the pixel clock and only clock (25.175 MHz nominal).
REQ-010 SHALL have port RST_N, input, 1, reset that is asynchronous and active-low.
REQ-011 SHALL have port LOCKED, input, 1, clock-generator lock status, asynchronous to PCK.
REQ-012 SHALL have port HCNT, output, 10, current horizontal position.
REQ-013 SHALL have port VCNT, output, 10, current vertical line.
REQ-014 SHALL have port HSYNC, output, 1, horizontal sync, active low.
REQ-015 SHALL have port VSYNC, output, 1, vertical sync, active low.
REQ-016 SHALL have port DISP_EN, output, 1, high during the visible area.
REQ-017 SHALL have port FRAME, output, 1, one-cycle pulse at each frame start.

Function
REQ-018 SHALL define HPERIOD = HVISIBLE+HFRONT+HWIDTH+HBACK (default 800) and VPERIOD = VVISIBLE+VFRONT+VWIDTH+VBACK (default 525).
REQ-019 SHALL synchronise LOCKED into PCK with a two-flop synchroniser; "run" means the synchronised LOCKED is 1.
REQ-020 SHALL, while not run, hold HCNT=0, VCNT=0, HSYNC=1, VSYNC=1, DISP_EN=0 and FRAME=0.
REQ-021 SHALL, while run, increment HCNT by 1 per PCK cycle and wrap HPERIOD-1 -> 0.
REQ-022 SHALL increment VCNT only on the cycle HCNT wraps, and wrap VPERIOD-1 -> 0 when both counters wrap together.
REQ-023 SHALL drive HSYNC=0 exactly when HVISIBLE+HFRONT <= HCNT <= HVISIBLE+HFRONT+HWIDTH-1 (default 656..751), aligned to the same cycle as HCNT.
REQ-024 SHALL drive VSYNC=0 exactly when VVISIBLE+VFRONT <= VCNT <= VVISIBLE+VFRONT+VWIDTH-1 (default 490..491), for whole lines.
REQ-025 SHALL drive DISP_EN=1 exactly when HCNT<HVISIBLE and VCNT<VVISIBLE.
REQ-026 SHALL pulse FRAME high for one cycle when the counters step from (HPERIOD-1, VPERIOD-1) to (0,0); it SHALL NOT pulse on leaving reset or on a lock gain.
REQ-027 SHALL drive HSYNC, VSYNC, DISP_EN and FRAME directly from flip-flops (glitch-free); they SHALL NOT be combinational decodes of the counters.
REQ-028 SHALL, when LOCKED falls mid-frame, return to the REQ-020 state two PCK cycles after the fall is sampled; on re-lock it SHALL restart from (0,0).
REQ-029 SHALL make the first run cycle after reset or re-lock show HCNT=0, VCNT=0, DISP_EN=1, HSYNC=1, VSYNC=1.

Reset
REQ-030 SHALL, while RST_N=0, asynchronously force the synchroniser flops, HCNT and VCNT to 0, DISP_EN=0, FRAME=0, HSYNC=1 and VSYNC=1.
REQ-031 SHALL leave reset synchronously: the first counter increment occurs no earlier than the third PCK edge after RST_N rises with LOCKED=1.

Verification
REQ-032 Bench SHALL hold LOCKED=1 and release reset -> HCNT 0..799 repeats; HSYNC low for exactly 96 cycles starting at HCNT=656; each line is 800 cycles.
REQ-033 Bench SHALL run one full frame -> VSYNC low for exactly 2x800 cycles starting at VCNT=490; DISP_EN high for exactly 640x480 cycles; frame length 420000 cycles.
REQ-034 Bench SHALL check FRAME -> exactly one single-cycle pulse per 420000 cycles, coincident with (0,0); no pulse in the first frame after reset.
REQ-035 Bench SHALL hold LOCKED=0 for 1000 cycles after reset -> HCNT=VCNT=0, HSYNC=VSYNC=1, DISP_EN=0 throughout; after LOCKED rises, counting starts within 3 cycles.
REQ-036 Bench SHALL drop LOCKED at VCNT=200, HCNT=300 -> outputs reach the REQ-020 state within 3 cycles; after re-lock, the first active cycle shows (0,0).
REQ-037 Bench SHALL assert RST_N=0 asynchronously mid-HSYNC -> HSYNC returns to 1 and the counters clear without a PCK edge.
